mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_responder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: single-port memory slave with programmable wait states.
//
// A request is accepted in IDLE. It then spends WAIT_CYCLES cycles in WAIT,
// one cycle in ACCESS (the block-RAM read or write), and one cycle in RESP.
// The response outputs are registered out of RESP, so resp_valid is high in
// the cycle after RESP. That cycle is already an IDLE cycle, which gives a
// throughput of one request per WAIT_CYCLES+3 cycles.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   req_valid/op/addr/size   request from the initiator
//   req_wdata                store data, right-justified
//   req_ready                high in IDLE (and not in reset)
//   resp_valid               one-cycle response strobe
//   resp_rdata               load/fetch data, zero-extended; 0 otherwise
//   resp_err                 request faulted; qualified by resp_valid
//   busy                     FSM is not in IDLE

package mem_responder_pkg;
    typedef struct packed {
        logic [31:0] high;
        logic [31:0] low;
    } memory_map_t;

    typedef enum logic [1:0] {
        MEM_NONE   = 2'd0,
        LOAD_DATA  = 2'd1,
        STORE_DATA = 2'd2,
        FETCH_DATA = 2'd3
    } memory_operation_t;

    typedef enum logic [1:0] {
        BYTE      = 2'd0,
        HALF_WORD = 2'd1,
        WORD      = 2'd2
    } access_size_t;
endpackage

module mem_responder
    import mem_responder_pkg::*;
#(
    parameter memory_map_t MAP         = '{high: 32'h0000_0FFF, low: 32'h0000_0000},
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  memory_operation_t req_op,
    input  logic [31:0]       req_addr,
    input  access_size_t      req_size,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              busy
);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

    state_t            state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    memory_operation_t op_reg;
    access_size_t      size_reg;
    logic [31:0]       addr_reg;
    logic [31:0]       wdata_reg;

    logic [31:0]       mem [0:DEPTH_WORDS-1];
    logic [31:0]       rd_word_reg;
    logic [7:0]        rd_lane [4];

    logic              resp_valid_reg;
    logic              resp_err_reg;
    logic [31:0]       resp_rdata_reg;

    logic              accept;
    logic              fault;
    logic [31:0]       word_off;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        be;
    logic [31:0]       wlane;
    logic              we;
    logic [31:0]       load_data;

    // Ready is forced low while reset is held, even though the FSM already
    // sits in IDLE.
    assign req_ready = (state_reg == IDLE) && !rst;
    assign accept    = req_valid && req_ready && (req_op != MEM_NONE);
    assign busy      = (state_reg != IDLE);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            op_reg    <= MEM_NONE;
            size_reg  <= BYTE;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                op_reg    <= req_op;
                size_reg  <= req_size;
                addr_reg  <= req_addr;
                wdata_reg <= req_wdata;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    cnt_next   = 4'(WAIT_CYCLES);
                    state_next = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                cnt_next = (cnt_reg != 4'd0) ? cnt_reg - 4'd1 : 4'd0;
                if (cnt_reg <= 4'd1) begin
                    state_next = ACCESS;
                end
            end
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- Fault decode on the latched request ----------------
    assign word_off = (addr_reg - MAP.low) >> 2;
    assign idx      = word_off[IDX_W-1:0];

    always_comb begin
        fault = 1'b0;
        if (addr_reg < MAP.low || addr_reg > MAP.high)          fault = 1'b1;
        if (word_off >= 32'(DEPTH_WORDS))                       fault = 1'b1;
        if (size_reg == HALF_WORD && addr_reg[0])               fault = 1'b1;
        if (size_reg == WORD && addr_reg[1:0] != 2'b00)         fault = 1'b1;
        if (op_reg == FETCH_DATA && size_reg != WORD)           fault = 1'b1;
        if (!(size_reg inside {BYTE, HALF_WORD, WORD}))         fault = 1'b1;
    end

    // ---------------- Store lane steering ----------------
    // Store data is replicated across lanes so each byte enable picks the
    // right source byte without a shifter.
    always_comb begin
        be    = 4'b1111;
        wlane = wdata_reg;
        case (size_reg)
            BYTE: begin
                be    = 4'b0001 << addr_reg[1:0];
                wlane = {4{wdata_reg[7:0]}};
            end
            HALF_WORD: begin
                be    = addr_reg[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wdata_reg[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = wdata_reg;
            end
        endcase
    end

    // During reset the FSM is held in IDLE, so an aborted store never writes.
    assign we = (state_reg == ACCESS) && (op_reg == STORE_DATA) && !fault;

    // Block RAM: no reset, registered read taken in ACCESS.
    always_ff @(posedge clk) begin
        if (state_reg == ACCESS) begin
            rd_word_reg <= mem[idx];
        end
        for (int b = 0; b < 4; b++) begin
            if (we && be[b]) begin
                mem[idx][b*8 +: 8] <= wlane[b*8 +: 8];
            end
        end
    end

    // ---------------- Load formatting ----------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rd_lane
            assign rd_lane[gi] = rd_word_reg[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        load_data = '0;
        case (size_reg)
            BYTE:      load_data = {24'b0, rd_lane[addr_reg[1:0]]};
            HALF_WORD: load_data = {16'b0, rd_lane[{addr_reg[1], 1'b1}],
                                           rd_lane[{addr_reg[1], 1'b0}]};
            default:   load_data = rd_word_reg;
        endcase
    end

    // ---------------- Registered response ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            resp_rdata_reg <= '0;
        end else begin
            resp_valid_reg <= (state_reg == RESP);
            resp_err_reg   <= (state_reg == RESP) && fault;
            resp_rdata_reg <= ((state_reg == RESP) && !fault && op_reg != STORE_DATA)
                              ? load_data : 32'h0;
        end
    end

    assign resp_valid = resp_valid_reg;
    assign resp_err   = resp_err_reg;
    assign resp_rdata = resp_rdata_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder. Two instances share the request bus:
// dut2 (WAIT_CYCLES=2) and dut0 (WAIT_CYCLES=0). Response latency is measured
// in falling edges after the accepting rising edge: it is WAIT_CYCLES+2.
module tb_mem_responder;
    import mem_responder_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    memory_operation_t req_op;
    logic [31:0]       req_addr;
    access_size_t      req_size;
    logic [31:0]       req_wdata;

    logic        ready2, valid2, err2, busy2;
    logic [31:0] rdata2;
    logic        ready0, valid0, err0, busy0;
    logic [31:0] rdata0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_responder #(.WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
        .req_size(req_size), .req_wdata(req_wdata),
        .req_ready(ready2), .resp_valid(valid2), .resp_rdata(rdata2),
        .resp_err(err2), .busy(busy2)
    );

    mem_responder #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
        .req_size(req_size), .req_wdata(req_wdata),
        .req_ready(ready0), .resp_valid(valid0), .resp_rdata(rdata0),
        .resp_err(err0), .busy(busy0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction on the instance selected by use0; checks latency,
    // data, error flag and that the strobe lasts one cycle.
    task automatic do_req(input bit use0, input memory_operation_t op,
                          input logic [31:0] addr, input access_size_t size,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input string tag);
        int k;
        int lat;
        lat = use0 ? 2 : 4;
        @(negedge clk);
        k = 0;
        while (!(use0 ? ready0 : ready2) && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "/ready"}, 32'(use0 ? ready0 : ready2), 32'd1);
        req_op    = op;
        req_addr  = addr;
        req_size  = size;
        req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // Inputs change after acceptance; the latched request must be used.
        req_valid = 1'b0;
        req_op    = STORE_DATA;
        req_addr  = $urandom;
        req_wdata = $urandom;
        chk({tag, "/busy"}, 32'(use0 ? busy0 : busy2), 32'd1);
        chk({tag, "/idle_rdata"}, use0 ? rdata0 : rdata2, 32'h0);
        k = 0;
        while (!(use0 ? valid0 : valid2) && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "/latency"}, 32'(k), 32'(lat));
        chk({tag, "/rdata"}, use0 ? rdata0 : rdata2, exp_rdata);
        chk({tag, "/err"}, 32'(use0 ? err0 : err2), 32'(exp_err));
        $display("[TB] txn %s op=%0d addr=%h size=%0d rdata=%h err=%0b lat=%0d",
                 tag, op, addr, size, use0 ? rdata0 : rdata2, use0 ? err0 : err2, k);
        @(negedge clk);
        chk({tag, "/strobe_end"}, 32'(use0 ? valid0 : valid2), 32'd0);
    endtask

    initial begin
        logic seen;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = MEM_NONE;
        req_addr  = '0;
        req_size  = BYTE;
        req_wdata = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst/ready", 32'(ready2), 32'd0);
        chk("rst/valid", 32'(valid2), 32'd0);
        chk("rst/rdata", rdata2, 32'h0);
        chk("rst/err", 32'(err2), 32'd0);
        chk("rst/busy", 32'(busy2), 32'd0);
        chk("rst/ready0", 32'(ready0), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst/ready_after", 32'(ready2), 32'd1);

        // Basic store/load
        do_req(0, STORE_DATA, 32'h10, WORD, 32'hDEAD_BEEF, 32'h0, 0, "st_w10");
        do_req(0, LOAD_DATA,  32'h10, WORD, 32'h0, 32'hDEAD_BEEF, 0, "ld_w10");

        // Lane handling
        do_req(0, STORE_DATA, 32'h10, WORD, 32'h1122_3344, 32'h0, 0, "st_w10b");
        do_req(0, STORE_DATA, 32'h13, BYTE, 32'h5555_55AA, 32'h0, 0, "st_b13");
        do_req(0, LOAD_DATA,  32'h10, WORD, 32'h0, 32'hAA22_3344, 0, "ld_w10b");
        do_req(0, LOAD_DATA,  32'h12, HALF_WORD, 32'h0, 32'h0000_AA22, 0, "ld_h12");
        do_req(0, LOAD_DATA,  32'h11, BYTE, 32'h0, 32'h0000_0033, 0, "ld_b11");
        do_req(0, STORE_DATA, 32'h10, HALF_WORD, 32'h9999_BEEF, 32'h0, 0, "st_h10");
        do_req(0, LOAD_DATA,  32'h10, WORD, 32'h0, 32'hAA22_BEEF, 0, "ld_w10c");

        // Faults leave storage untouched
        do_req(0, LOAD_DATA,  32'h1000, WORD, 32'h0, 32'h0, 1, "ld_out");
        do_req(0, LOAD_DATA,  32'h11, HALF_WORD, 32'h0, 32'h0, 1, "ld_h_mis");
        do_req(0, STORE_DATA, 32'h12, WORD, 32'hFFFF_FFFF, 32'h0, 1, "st_w_mis");
        do_req(0, LOAD_DATA,  32'h10, WORD, 32'h0, 32'hAA22_BEEF, 0, "ld_w10d");

        // Last word of the window
        do_req(0, STORE_DATA, 32'hFFC, WORD, 32'hCAFE_F00D, 32'h0, 0, "st_wffc");
        do_req(0, LOAD_DATA,  32'hFFC, WORD, 32'h0, 32'hCAFE_F00D, 0, "ld_wffc");

        // Fetch
        do_req(0, FETCH_DATA, 32'h0,  BYTE, 32'h0, 32'h0, 1, "fe_b0");
        do_req(0, FETCH_DATA, 32'h10, WORD, 32'h0, 32'hAA22_BEEF, 0, "fe_w10");

        // Reset during WAIT aborts a store
        do_req(0, STORE_DATA, 32'h20, WORD, 32'h0BAD_F00D, 32'h0, 0, "st_w20");
        @(negedge clk);
        req_op    = STORE_DATA;
        req_addr  = 32'h20;
        req_size  = WORD;
        req_wdata = 32'h1234_5678;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort/busy_wait", 32'(busy2), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort/busy_rst", 32'(busy2), 32'd0);
        chk("abort/ready_rst", 32'(ready2), 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | valid2 | valid0;
        end
        chk("abort/no_resp", 32'(seen), 32'd0);
        do_req(0, LOAD_DATA, 32'h20, WORD, 32'h0, 32'h0BAD_F00D, 0, "ld_w20");
        do_req(0, LOAD_DATA, 32'h10, WORD, 32'h0, 32'hAA22_BEEF, 0, "ld_keep");

        // WAIT_CYCLES=0: MEM_NONE is ignored, then a load
        @(negedge clk);
        req_op    = MEM_NONE;
        req_addr  = 32'h10;
        req_size  = WORD;
        req_valid = 1'b1;
        seen      = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | busy0 | valid0 | busy2 | valid2;
        end
        req_valid = 1'b0;
        chk("none/ignored", 32'(seen), 32'd0);
        do_req(1, LOAD_DATA, 32'h10, WORD, 32'h0, 32'hAA22_BEEF, 0, "w0_ld_w10");
        do_req(1, LOAD_DATA, 32'h12, HALF_WORD, 32'h0, 32'h0000_AA22, 0, "w0_ld_h12");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
